// File: rtl/ddr2_burst_scheduler.sv
// Moves whole bursts between the inbound/outbound FIFOs and an MCB user port.
// Writes push BURST_LEN words before their command; reads issue the command and then drain BURST_LEN words.
module ddr2_burst_scheduler #(
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned OB_DEPTH   = 1024,
  parameter logic [29:0] ADDR_LIMIT = 30'h0800_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        calib_done,
  input  logic        writes_en,
  input  logic        reads_en,
  input  logic [10:0] ib_count,
  input  logic [31:0] ib_data,
  output logic        ib_re,
  input  logic [10:0] ob_count,
  output logic        ob_we,
  output logic [31:0] ob_data,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_byte_addr,
  input  logic        p0_cmd_full,
  output logic        p0_wr_en,
  output logic [31:0] p0_wr_data,
  output logic [3:0]  p0_wr_mask,
  input  logic        p0_wr_full,
  output logic        p0_rd_en,
  input  logic [31:0] p0_rd_data,
  input  logic        p0_rd_empty,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_CMD  = 3'd2,
    RD_CMD  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam int unsigned CW        = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [29:0] ADDR_STEP = 30'(BURST_LEN * 4);
  localparam logic [10:0] IB_THRESH = 11'(BURST_LEN);
  localparam logic [10:0] OB_THRESH = 11'(OB_DEPTH - BURST_LEN);
  localparam logic [5:0]  CMD_BL    = 6'(BURST_LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [29:0]   wr_addr_q, wr_addr_d;
  logic [29:0]   rd_addr_q, rd_addr_d;
  logic          last_grant_q, last_grant_d;
  logic          wr_ok, rd_ok;

  function automatic logic [29:0] next_addr(input logic [29:0] addr);
    logic [29:0] sum;
    sum = addr + ADDR_STEP;
    return (sum == ADDR_LIMIT) ? 30'd0 : sum;
  endfunction

  assign wr_ok = calib_done & writes_en & (ib_count >= IB_THRESH);
  assign rd_ok = calib_done & reads_en & (ob_count <= OB_THRESH);

  assign p0_wr_data       = ib_data;
  assign ob_data          = p0_rd_data;
  assign p0_wr_mask       = 4'b0000;
  assign p0_cmd_bl        = CMD_BL;
  assign p0_cmd_byte_addr = (state_q == RD_CMD) ? rd_addr_q : wr_addr_q;
  assign busy             = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wr_addr_q    <= 30'd0;
      rd_addr_q    <= 30'd0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // last_grant is 1 after a write burst; a tie goes to the other side.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    last_grant_d = last_grant_q;
    ib_re        = 1'b0;
    p0_wr_en     = 1'b0;
    p0_cmd_en    = 1'b0;
    p0_cmd_instr = 3'b000;
    p0_rd_en     = 1'b0;
    ob_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ok && (!rd_ok || !last_grant_q)) begin
          state_d      = WR_DATA;
          last_grant_d = 1'b1;
        end else if (rd_ok) begin
          state_d      = RD_CMD;
          last_grant_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (!p0_wr_full) begin
          ib_re    = 1'b1;
          p0_wr_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = WR_CMD;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      WR_CMD: begin
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          wr_addr_d = next_addr(wr_addr_q);
          state_d   = IDLE;
        end else begin
          state_d = WR_CMD;
        end
      end
      RD_CMD: begin
        p0_cmd_instr = 3'b001;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          rd_addr_d = next_addr(rd_addr_q);
          state_d   = RD_DATA;
        end else begin
          state_d = RD_CMD;
        end
      end
      RD_DATA: begin
        if (!p0_rd_empty) begin
          p0_rd_en = 1'b1;
          ob_we    = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ddr2_burst_scheduler.sv
// Scoreboard bench for ddr2_burst_scheduler: stimulus queues expected words and commands,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ddr2_burst_scheduler;

  localparam int          BL  = 32;
  localparam int          OBD = 1024;
  localparam logic [29:0] AL  = 30'h100;

  typedef struct packed {
    logic [2:0]  instr;
    logic [29:0] addr;
  } cmd_t;

  logic        clk, reset_n, calib_done, writes_en, reads_en;
  logic [10:0] ib_count, ob_count;
  logic [31:0] ib_data, ob_data, p0_wr_data, p0_rd_data;
  logic        ib_re, ob_we, p0_cmd_en, p0_cmd_full, p0_wr_en, p0_wr_full;
  logic        p0_rd_en, p0_rd_empty, busy;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic [3:0]  p0_wr_mask;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];
  cmd_t        cmd_q[$];
  int          cmd_cnt, wr_beats;
  logic        ib_pop, rd_pop, bp_en;
  logic [31:0] ib_word, rd_word;

  ddr2_burst_scheduler #(.BURST_LEN(BL), .OB_DEPTH(OBD), .ADDR_LIMIT(AL)) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done), .writes_en(writes_en),
    .reads_en(reads_en), .ib_count(ib_count), .ib_data(ib_data), .ib_re(ib_re),
    .ob_count(ob_count), .ob_we(ob_we), .ob_data(ob_data), .p0_cmd_en(p0_cmd_en),
    .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl), .p0_cmd_byte_addr(p0_cmd_byte_addr),
    .p0_cmd_full(p0_cmd_full), .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data),
    .p0_wr_mask(p0_wr_mask), .p0_wr_full(p0_wr_full), .p0_rd_en(p0_rd_en),
    .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ib_data    = 32'hA000_0000 + ib_word;
  assign p0_rd_data = 32'hC000_0000 + rd_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FWFT inbound head and MCB read head advance after each popped beat.
  initial begin
    ib_word = 32'd0;
    rd_word = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (ib_pop) ib_word = ib_word + 32'd1;
      if (rd_pop) rd_word = rd_word + 32'd1;
    end
  end

  initial begin
    p0_wr_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) p0_wr_full = ~p0_wr_full;
      else p0_wr_full = 1'b0;
    end
  end

  // Monitor: compare every beat and command against the scoreboard queues.
  initial begin
    cmd_t c;
    ib_pop   = 1'b0;
    rd_pop   = 1'b0;
    cmd_cnt  = 0;
    wr_beats = 0;
    forever begin
      @(negedge clk);
      ib_pop = 1'b0;
      rd_pop = 1'b0;
      if (!reset_n) begin
        wr_beats = 0;
      end else begin
        if (!busy)
          check("idle_strobes", {27'd0, p0_cmd_en, ib_re, p0_wr_en, p0_rd_en, ob_we}, 32'd0);
        if (busy && p0_wr_full) check("wr_full_hold", 32'(p0_wr_en | ib_re), 32'd0);
        if (busy && p0_rd_empty) check("rd_empty_hold", 32'(p0_rd_en | ob_we), 32'd0);
        if (busy && p0_cmd_full) check("cmd_full_hold", 32'(p0_cmd_en), 32'd0);
        if (ib_re || p0_wr_en) begin
          check("wr_pair", 32'(ib_re), 32'(p0_wr_en));
          check("wr_beat_expected", 32'(wr_q.size() != 0), 32'd1);
          if (wr_q.size() != 0) check("wr_data", p0_wr_data, wr_q.pop_front());
          ib_pop   = p0_wr_en;
          wr_beats = wr_beats + 1;
        end
        if (p0_rd_en || ob_we) begin
          check("rd_pair", 32'(p0_rd_en), 32'(ob_we));
          check("rd_beat_expected", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) check("ob_data", ob_data, rd_q.pop_front());
          rd_pop = p0_rd_en;
        end
        if (p0_cmd_en) begin
          cmd_cnt = cmd_cnt + 1;
          check("cmd_bl", 32'(p0_cmd_bl), 32'd31);
          check("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
          if (cmd_q.size() != 0) begin
            c = cmd_q.pop_front();
            check("cmd_instr", 32'(p0_cmd_instr), 32'(c.instr));
            check("cmd_addr", 32'(p0_cmd_byte_addr), 32'(c.addr));
          end
          if (p0_cmd_instr == 3'b000) begin
            check("wr_beats_before_cmd", 32'(wr_beats), 32'd32);
            wr_beats = 0;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input int n);
    for (int i = 0; i < n; i++) wr_q.push_back(32'hA000_0000 + ib_word + 32'(i));
  endtask

  task automatic push_rd(input int n);
    for (int i = 0; i < n; i++) rd_q.push_back(32'hC000_0000 + rd_word + 32'(i));
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [29:0] addr);
    cmd_t c;
    c.instr = instr;
    c.addr  = addr;
    cmd_q.push_back(c);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 20) begin
      cycles(1);
      n++;
    end
    check(name, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      cycles(1);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic queues_empty(input string name);
    check(name, 32'(wr_q.size() + rd_q.size() + cmd_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int c0;
    reset_n = 1'b0; calib_done = 1'b0; writes_en = 1'b0; reads_en = 1'b0;
    ib_count = 11'd0; ob_count = 11'd0; p0_cmd_full = 1'b0; p0_rd_empty = 1'b1;
    bp_en = 1'b0;
    cycles(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", {27'd0, p0_cmd_en, ib_re, p0_wr_en, p0_rd_en, ob_we}, 32'd0);
    check("rst_addr", 32'(p0_cmd_byte_addr), 32'd0);
    check("wr_mask", 32'(p0_wr_mask), 32'd0);
    reset_n = 1'b1;
    cycles(2);
    calib_done = 1'b1;
    ib_count   = 11'd32;

    // single write burst, enable dropped mid-burst
    push_wr(32); push_cmd(3'b000, 30'h000);
    writes_en = 1'b1; wait_busy("w1_start"); writes_en = 1'b0;
    wait_idle("w1_done"); queues_empty("w1_queues");

    // write with data and command backpressure
    push_wr(32); push_cmd(3'b000, 30'h080);
    bp_en = 1'b1; p0_cmd_full = 1'b1;
    writes_en = 1'b1; wait_busy("bp_start"); writes_en = 1'b0;
    n = 0;
    while (wr_beats < 32 && n < 200) begin cycles(1); n++; end
    check("bp_beats", 32'(wr_beats), 32'd32);
    bp_en = 1'b0;
    c0 = cmd_cnt;
    cycles(5);
    check("bp_cmd_held_busy", 32'(busy), 32'd1);
    check("bp_cmd_held_count", 32'(cmd_cnt), 32'(c0));
    p0_cmd_full = 1'b0;
    wait_idle("bp_done"); queues_empty("bp_queues");

    // read burst; MCB read FIFO empty until after the command
    push_rd(32); push_cmd(3'b001, 30'h000);
    reads_en = 1'b1; wait_busy("r1_start"); reads_en = 1'b0;
    cycles(3);
    check("r1_stall_busy", 32'(busy), 32'd1);
    p0_rd_empty = 1'b0;
    wait_idle("r1_done"); queues_empty("r1_queues");

    // both eligible: W,R,W,R with write address wrapping to 0
    push_wr(64); push_rd(64);
    push_cmd(3'b000, 30'h000); push_cmd(3'b001, 30'h080);
    push_cmd(3'b000, 30'h080); push_cmd(3'b001, 30'h000);
    c0 = cmd_cnt;
    writes_en = 1'b1; reads_en = 1'b1;
    n = 0;
    while (cmd_cnt < c0 + 4 && n < 1000) begin cycles(1); n++; end
    writes_en = 1'b0; reads_en = 1'b0;
    check("arb_cmds", 32'(cmd_cnt - c0), 32'd4);
    wait_idle("arb_done"); queues_empty("arb_queues");

    // outbound FIFO one word too full for a burst
    ob_count = 11'(OBD - 31);
    c0 = cmd_cnt;
    reads_en = 1'b1;
    cycles(40);
    check("gate_busy", 32'(busy), 32'd0);
    check("gate_cmds", 32'(cmd_cnt), 32'(c0));
    reads_en = 1'b0; ob_count = 11'd0;

    // reset mid write burst
    push_wr(32);
    c0 = cmd_cnt;
    writes_en = 1'b1; wait_busy("rst_start"); writes_en = 1'b0;
    n = 0;
    while (wr_beats < 5 && n < 50) begin cycles(1); n++; end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_strobes", {27'd0, p0_cmd_en, ib_re, p0_wr_en, p0_rd_en, ob_we}, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    wr_q.delete();
    cycles(2);
    check("rst_mid_cmds", 32'(cmd_cnt), 32'(c0));
    reset_n = 1'b1;
    cycles(2);

    // addresses restart at 0 after reset
    push_rd(32); push_cmd(3'b001, 30'h000);
    reads_en = 1'b1; wait_busy("r2_start"); reads_en = 1'b0;
    wait_idle("r2_done"); queues_empty("r2_queues");
    push_wr(32); push_cmd(3'b000, 30'h000);
    writes_en = 1'b1; wait_busy("w3_start"); writes_en = 1'b0;
    wait_idle("w3_done"); queues_empty("w3_queues");

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr2_burst_scheduler.md
DDR2_BURST_SCHEDULER -- requirements
Module: ddr2_burst_scheduler

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, 32-bit words per MCB burst (1..64).
REQ-002 SHALL have parameter OB_DEPTH, default 1024, outbound FIFO capacity in words.
REQ-003 SHALL have parameter ADDR_LIMIT, default 30'h0800_0000, byte address wrap point; multiple of BURST_LEN*4.
REQ-004 SHALL have the following ports:
- clk  in  1  sole clock, MCB p0 user clock domain.
- reset_n  in  1  reset, asynchronous, active-low.
- calib_done  in  1  MCB calibration complete.
- writes_en  in  1  write path enabled.
- reads_en  in  1  read path enabled.
- ib_count  in  11  inbound FWFT FIFO occupancy, words.
- ib_data  in  32  inbound FIFO head word.
- ib_re  out  1  inbound FIFO pop.
- ob_count  in  11  outbound FIFO occupancy, words.
- ob_we  out  1  outbound FIFO push.
- ob_data  out  32  outbound FIFO write data.
- p0_cmd_en  out  1  MCB command strobe.
- p0_cmd_instr  out  3  000 write, 001 read.
- p0_cmd_bl  out  6  burst length minus one.
- p0_cmd_byte_addr  out  30  burst byte address.
- p0_cmd_full  in  1  MCB command FIFO full.
- p0_wr_en  out  1  MCB write-data push.
- p0_wr_data  out  32  MCB write data.
- p0_wr_mask  out  4  byte mask, constant 0.
- p0_wr_full  in  1  MCB write FIFO full.
- p0_rd_en  out  1  MCB read-data pop.
- p0_rd_data  in  32  MCB read data.
- p0_rd_empty  in  1  MCB read FIFO empty.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement states IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA in one registered state register.
REQ-006 SHALL define wr_ok = calib_done & writes_en & (ib_count >= BURST_LEN).
REQ-007 SHALL define rd_ok = calib_done & reads_en & (ob_count <= OB_DEPTH-BURST_LEN).
REQ-008 IDLE SHALL: wr_ok only -> WR_DATA; rd_ok only -> RD_CMD; both -> opposite of last_grant; neither -> stay.
REQ-009 SHALL update last_grant on leaving IDLE (write=1, read=0); round-robin when both requesters are eligible.
REQ-010 WR_DATA SHALL assert ib_re and p0_wr_en together, combinationally, in each cycle with p0_wr_full=0; p0_wr_data = ib_data.
REQ-011 SHALL hold both strobes low while p0_wr_full=1, without counting the beat.
REQ-012 WR_DATA SHALL go to WR_CMD after exactly BURST_LEN beats.
REQ-013 WR_CMD SHALL, in the first cycle with p0_cmd_full=0, pulse p0_cmd_en for 1 cycle (instr 000, bl BURST_LEN-1, addr wr_addr).
REQ-014 On that cycle wr_addr SHALL advance by BURST_LEN*4, with result equal to ADDR_LIMIT wrapping to 0; state -> IDLE.
REQ-015 RD_CMD SHALL issue the same way with instr 001 and addr rd_addr, advance and wrap rd_addr identically, then go to RD_DATA.
REQ-016 RD_DATA SHALL assert p0_rd_en and ob_we together in each cycle with p0_rd_empty=0; ob_data = p0_rd_data.
REQ-017 RD_DATA SHALL go to IDLE after exactly BURST_LEN beats.
REQ-018 Write data SHALL always precede its command; a command is never issued before its BURST_LEN words are pushed.
REQ-019 A started burst SHALL complete even if writes_en, reads_en or calib_done deasserts mid-burst.
REQ-020 p0_cmd_en, ib_re, p0_wr_en, p0_rd_en and ob_we SHALL never assert in IDLE.
REQ-021 wr_addr and rd_addr SHALL be independent 30-bit registers; beat counter width = clog2(BURST_LEN+1).

Reset
REQ-022 reset_n low SHALL asynchronously force state IDLE, wr_addr=0, rd_addr=0, beat counter=0, last_grant=read (write wins first tie), all strobes 0, busy 0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst with no further strobes; the outstanding MCB/FIFO contents are the caller's responsibility.
REQ-024 Deassertion SHALL be used synchronously to clk.

Verification
REQ-025 Single write: ib_count=32, writes_en=1, calib_done=1 -> 32 consecutive ib_re/p0_wr_en, then 1 p0_cmd_en instr 000 bl 31 addr 0; next write addr 0x80.
REQ-026 Backpressure: p0_wr_full toggles every other cycle during WR_DATA -> still exactly 32 beats; cmd held while p0_cmd_full=1 for 5 cycles, then issued once.
REQ-027 Arbitration: wr_ok and rd_ok both held high -> bursts alternate W,R,W,R.
REQ-028 Read: reads_en=1, ob_count=0, p0_rd_empty low after cmd -> 1 read cmd at rd_addr 0, then 32 p0_rd_en/ob_we pairs with ob_data = p0_rd_data.
REQ-029 Read gating: ob_count=OB_DEPTH-31 -> no read command issued.
REQ-030 Wrap and reset: ADDR_LIMIT=0x100, BURST_LEN=32 -> write addrs 0x00, 0x80, 0x00; reset_n pulsed in WR_DATA -> strobes drop immediately, addrs return to 0.
